// File: rtl/osc_freq_meter_ctrl.sv
// osc_freq_meter_ctrl: sequencer for a ring-oscillator macro.
// On start it enables the oscillator, waits WARM_CYC clk cycles, counts synchronized rising edges
// of tout over a gate window of gate_cycles clk cycles, then stops the oscillator and reports the
// edge count with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   start         1-cycle request, accepted only while idle
//   abort         cancel an active measurement (wins over start)
//   gate_cycles   gate window length in clk cycles (0 behaves as 1), sampled on accept
//   osc_start     oscillator enable, high from warm-up through measure
//   tout          oscillator output, asynchronous to clk
//   busy          high whenever not idle
//   done          1-cycle result-valid pulse
//   count         edges counted in the last window, held until next accepted start
//   overflow      counter saturated during the last measurement
//   stuck         (only with OSC_MEAS_STUCK_EN) full window completed with zero edges
//
// Optional feature macro: OSC_MEAS_STUCK_EN adds the stuck output.
module osc_freq_meter_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned GATE_W   = 16,
  parameter int unsigned WARM_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              osc_start,
  input  logic              tout,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
`ifdef OSC_MEAS_STUCK_EN
  output logic              stuck,
`endif
  output logic              overflow
);

  localparam int unsigned WarmW = $clog2(WARM_CYC + 1);
  localparam int unsigned TmrW  = (GATE_W > WarmW) ? GATE_W : WarmW;

  typedef enum logic [1:0] {StIdle, StWarmup, StMeasure, StDone} state_e;

  state_e              state_q, state_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                sync1_q, sync2_q, hist_q;
  logic                osc_q, busy_q, done_q;
  logic                tout_edge;
`ifdef OSC_MEAS_STUCK_EN
  logic                stuck_q, stuck_d;
`endif

  assign tout_edge = sync2_q & ~hist_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    gate_d  = gate_q;
    count_d = count_q;
    ovf_d   = ovf_q;
`ifdef OSC_MEAS_STUCK_EN
    stuck_d = stuck_q;
`endif

    // Edge accumulation runs for every measure cycle, including one being aborted.
    if (state_q == StMeasure && tout_edge) begin
      if (count_q == {CNT_W{1'b1}}) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StWarmup;
          gate_d  = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
          tmr_d   = TmrW'(WARM_CYC - 1);
          count_d = '0;
          ovf_d   = 1'b0;
`ifdef OSC_MEAS_STUCK_EN
          stuck_d = 1'b0;
`endif
        end
      end
      StWarmup: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tmr_q == '0) begin
          state_d = StMeasure;
          tmr_d   = TmrW'(gate_q) - 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StMeasure: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tmr_q == '0) begin
          state_d = StDone;
`ifdef OSC_MEAS_STUCK_EN
          stuck_d = (count_d == '0);
`endif
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StDone: begin
        // The done pulse is already registered, so abort has nothing left to cancel.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      gate_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      osc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      gate_q  <= gate_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      sync1_q <= tout;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      // Outputs registered from next state so osc_start is glitch-free toward the macro.
      osc_q   <= (state_d == StWarmup) || (state_d == StMeasure);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
    end
  end

`ifdef OSC_MEAS_STUCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
    end
  end
  assign stuck = stuck_q;
`endif

  assign osc_start = osc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_osc_freq_meter_ctrl.sv
// Directed testbench for osc_freq_meter_ctrl: two instances (CNT_W=16 and CNT_W=4) share stimulus.
module tb_osc_freq_meter_ctrl;

  localparam int W = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] gate_cycles;
  logic        tout;
  logic        tout_gen;
  logic        tout_run;
  logic        osc_start, busy, done, overflow;
  logic [15:0] count;
  logic        osc_start4, busy4, done4, overflow4;
  logic [3:0]  count4;
`ifdef OSC_MEAS_STUCK_EN
  logic        stuck, stuck4;
`endif

  int total;
  int bad;

  osc_freq_meter_ctrl #(.CNT_W(16), .GATE_W(16), .WARM_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_cycles(gate_cycles),
    .osc_start(osc_start), .tout(tout), .busy(busy), .done(done), .count(count),
`ifdef OSC_MEAS_STUCK_EN
    .stuck(stuck),
`endif
    .overflow(overflow)
  );

  osc_freq_meter_ctrl #(.CNT_W(4), .GATE_W(16), .WARM_CYC(W)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_cycles(gate_cycles),
    .osc_start(osc_start4), .tout(tout), .busy(busy4), .done(done4), .count(count4),
`ifdef OSC_MEAS_STUCK_EN
    .stuck(stuck4),
`endif
    .overflow(overflow4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tout = clk/4 square wave with an arbitrary phase offset, gated by tout_run.
  initial begin
    tout_gen = 1'b0;
    #3;
    forever #20 tout_gen = ~tout_gen;
  end
  assign tout = tout_run & tout_gen;

  // Pulse start for one clk edge; returns at the first negedge after that edge (cycle k+1).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges from cycle k+1; lat is the first cycle index with done high, nd the pulses.
  task automatic wait_done(input int budget, output int lat, output int nd);
    lat = 0;
    nd  = 0;
    for (int n = 1; n <= budget; n++) begin
      if (n > 1) @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        if (lat == 0) lat = n;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (osc_start !== 1'b0) begin bad++; $display("FAIL reset_osc got=%b exp=0", osc_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
`ifdef OSC_MEAS_STUCK_EN
    total++; if (stuck !== 1'b0) begin bad++; $display("FAIL reset_stuck got=%b exp=0", stuck); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, nd;
    gate_cycles = 16'd100;
    pulse_start();
    total++; if (osc_start !== 1'b1) begin bad++; $display("FAIL basic_osc_on got=%b exp=1", osc_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_done(130, lat, nd);
    total++; if (lat !== W + 101) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 101); end
    total++; if (nd !== 1) begin bad++; $display("FAIL basic_ndone got=%0d exp=1", nd); end
    total++; if (count < 16'd24 || count > 16'd26) begin bad++; $display("FAIL basic_count got=%0d exp=25", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
    total++; if (osc_start !== 1'b0) begin bad++; $display("FAIL basic_osc_off got=%b exp=0", osc_start); end
`ifdef OSC_MEAS_STUCK_EN
    total++; if (stuck !== 1'b0) begin bad++; $display("FAIL basic_stuck got=%b exp=0", stuck); end
`endif
  endtask

  task automatic test_saturation();
    int lat4;
    gate_cycles = 16'd100;
    pulse_start();
    lat4 = 0;
    for (int n = 1; n <= 130; n++) begin
      if (n > 1) @(negedge clk);
      if (done4 === 1'b1 && lat4 == 0) lat4 = n;
    end
    total++; if (lat4 !== W + 101) begin bad++; $display("FAIL sat_latency got=%0d exp=%0d", lat4, W + 101); end
    total++; if (count4 !== 4'd15) begin bad++; $display("FAIL sat_count got=%0d exp=15", count4); end
    total++; if (overflow4 !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", overflow4); end
  endtask

  task automatic test_start_while_busy();
    int lat, nd, busy_drop;
    gate_cycles = 16'd100;
    pulse_start();
    lat = 0; nd = 0; busy_drop = 0;
    for (int n = 1; n <= 130; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 50) start = 1'b1;
      if (n == 51) start = 1'b0;
      if (n <= W + 101 && busy !== 1'b1) busy_drop++;
      if (done === 1'b1) begin
        nd++;
        if (lat == 0) lat = n;
      end
    end
    total++; if (busy_drop !== 0) begin bad++; $display("FAIL busy_hold got=%0d drops exp=0", busy_drop); end
    total++; if (nd !== 1) begin bad++; $display("FAIL busy_ndone got=%0d exp=1", nd); end
    total++; if (lat !== W + 101) begin bad++; $display("FAIL busy_latency got=%0d exp=%0d", lat, W + 101); end
    total++; if (count < 16'd24 || count > 16'd26) begin bad++; $display("FAIL busy_count got=%0d exp=25", count); end
  endtask

  task automatic test_abort();
    int lat, nd;
    // start and abort together while idle: stays idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle_busy got=%b exp=0", busy); end
    gate_cycles = 16'd100;
    pulse_start();
    // measure begins at cycle W+1; abort five cycles later
    repeat (W + 5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (osc_start !== 1'b0) begin bad++; $display("FAIL abort_osc got=%b exp=0", osc_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    wait_done(20, lat, nd);
    total++; if (nd !== 0) begin bad++; $display("FAIL abort_nodone got=%0d exp=0", nd); end
    total++; if (count > 16'd3) begin bad++; $display("FAIL abort_partial got=%0d exp<=3", count); end
    pulse_start();
    wait_done(130, lat, nd);
    total++; if (lat !== W + 101) begin bad++; $display("FAIL abort_rerun_lat got=%0d exp=%0d", lat, W + 101); end
    total++; if (count < 16'd24 || count > 16'd26) begin bad++; $display("FAIL abort_rerun_count got=%0d exp=25", count); end
  endtask

  task automatic test_reset_mid();
    int lat, nd;
    gate_cycles = 16'd100;
    pulse_start();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (osc_start !== 1'b0) begin bad++; $display("FAIL rstmid_osc got=%b exp=0", osc_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    total++; if (overflow4 !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%b exp=0", overflow4); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    wait_done(130, lat, nd);
    total++; if (lat !== W + 101) begin bad++; $display("FAIL rstmid_rerun_lat got=%0d exp=%0d", lat, W + 101); end
    total++; if (count < 16'd24 || count > 16'd26) begin bad++; $display("FAIL rstmid_rerun_count got=%0d exp=25", count); end
  endtask

  task automatic test_gate_zero();
    int lat, nd;
    tout_run = 1'b0;
    repeat (5) @(negedge clk);
    gate_cycles = 16'd0;
    pulse_start();
    gate_cycles = 16'd50;  // must not affect the accepted measurement
    wait_done(30, lat, nd);
    total++; if (lat !== W + 2) begin bad++; $display("FAIL gate0_latency got=%0d exp=%0d", lat, W + 2); end
    total++; if (nd !== 1) begin bad++; $display("FAIL gate0_ndone got=%0d exp=1", nd); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL gate0_count got=%0d exp=0", count); end
`ifdef OSC_MEAS_STUCK_EN
    total++; if (stuck !== 1'b1) begin bad++; $display("FAIL gate0_stuck got=%b exp=1", stuck); end
`endif
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gate_cycles = 16'd100; tout_run = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    test_gate_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
